// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the interrupt arbiter (FSM encoding, register offsets, arbitration modes)
package irq_pkg;
    localparam logic [1:0] IRQ_IDLE     = 2'd0;
    localparam logic [1:0] IRQ_RAISE_ST = 2'd1;
    localparam logic [1:0] IRQ_HOLD     = 2'd2;
    localparam logic [7:0] IRQ_REG_MASK   = 8'd0;
    localparam logic [7:0] IRQ_REG_PEND   = 8'd1;
    localparam logic [7:0] IRQ_REG_ACTIVE = 8'd2;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
endpackage

// File: rtl/irq_prio_sel.sv
// irq_prio_sel: combinational first-set-bit search starting at start, wrapping modulo NUM_SRC
module irq_prio_sel #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] vec,
    input  logic [2:0]         start,
    output logic               found,
    output logic [2:0]         idx
);
    // Scan from the farthest offset down so the nearest set bit is the last write
    always_comb begin
        idx = 3'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (vec[(int'(start) + k) % NUM_SRC]) idx = 3'((int'(start) + k) % NUM_SRC);
        end
    end
    assign found = |vec;
endmodule

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: latches peripheral requests, masks and arbitrates them onto one raise/ack pair,
// exposing MASK, PENDING and ACTIVE registers on the shared memory-mapped bus.
module interrupt_arbiter
    import irq_pkg::*;
#(
    parameter int         NUM_SRC    = 8,
    parameter logic [7:0] BASE_ADDR  = 8'hC0,
    parameter int         ARB_MODE   = 0,
    parameter logic [7:0] LEVEL_MASK = 8'h00
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] SRC_REQ,
    input  logic [7:0]         BUS_ADDR,
    inout  wire  [7:0]         BUS_DATA,
    input  logic               BUS_WE,
    output logic               IRQ_RAISE,
    input  logic               IRQ_ACK
);
    localparam logic [NUM_SRC-1:0] LVL = LEVEL_MASK[NUM_SRC-1:0];

    logic [1:0]         state, state_n;
    logic [NUM_SRC-1:0] req_q, pend_e, mask, pending, eligible, clr;
    logic [2:0]         id, rr_ptr, rr_n, start, win;
    logic [7:0]         off, pend8, ack_vec, rdata;
    logic               found, ack, rd;

    assign off      = BUS_ADDR - BASE_ADDR;
    assign pending  = (pend_e & ~LVL) | (req_q & LVL);
    assign pend8    = 8'(pending);
    assign eligible = pending & mask;
    assign start    = (ARB_MODE == ARB_RR) ? rr_ptr : 3'd0;

    irq_prio_sel #(.NUM_SRC(NUM_SRC)) u_sel (
        .vec  (eligible),
        .start(start),
        .found(found),
        .idx  (win)
    );

    assign ack     = (state == IRQ_RAISE_ST) && IRQ_ACK;
    assign ack_vec = ack ? (8'd1 << id) : 8'd0;
    assign clr     = ack_vec[NUM_SRC-1:0] | ((BUS_WE && off == IRQ_REG_PEND) ? BUS_DATA[NUM_SRC-1:0] : '0);
    assign rr_n    = (id == 3'(NUM_SRC - 1)) ? 3'd0 : id + 3'd1;

    assign rd    = !BUS_WE && off <= IRQ_REG_ACTIVE;
    assign rdata = off == IRQ_REG_MASK ? 8'(mask) :
                   off == IRQ_REG_PEND ? pend8 : {state != IRQ_IDLE, 4'b0, id};
    assign BUS_DATA = rd ? rdata : 8'bz;

    // A request withdrawn while raised returns to IDLE without touching rr_ptr
    assign state_n = state == IRQ_IDLE     ? (found ? IRQ_RAISE_ST : IRQ_IDLE) :
                     state == IRQ_RAISE_ST ? (IRQ_ACK ? IRQ_HOLD : pend8[id] ? IRQ_RAISE_ST : IRQ_IDLE) :
                     IRQ_IDLE;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IRQ_IDLE;
            IRQ_RAISE <= 1'b0;
            req_q     <= '0;
            pend_e    <= '0;
            mask      <= '0;
            id        <= 3'd0;
            rr_ptr    <= 3'd0;
        end else begin
            state     <= state_n;
            IRQ_RAISE <= state_n == IRQ_RAISE_ST;
            req_q     <= SRC_REQ;
            pend_e    <= ((pend_e & ~clr) | (SRC_REQ & ~req_q)) & ~LVL;
            if (BUS_WE && off == IRQ_REG_MASK) mask <= BUS_DATA[NUM_SRC-1:0];
            if (state == IRQ_IDLE && found) id <= win;
            if (ack) rr_ptr <= rr_n;
        end
    end
endmodule
